// File: rtl/grant_burst_ctrl.sv
// Locks onto a one-hot arbiter grant and moves a fixed-length burst
// from the granted requester to one shared valid/ready output port.
module grant_burst_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          grnt,
  input  logic [4*DATA_W-1:0] req_data,
  input  logic [3:0]          req_valid,
  output logic [3:0]          req_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          done,
  output logic [3:0]          abort,
  output logic                busy,
  output logic                err_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    REL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       done_nxt, abort_nxt;
  logic             err_nxt;
  logic [1:0]       enc;
  logic             one_hot;
  logic             beat;

  always_comb begin
    enc = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grnt[i]) enc = 2'(i);
    end
  end

  assign one_hot = (grnt != 4'd0) &&
                   ((grnt & (grnt - 4'd1)) == 4'd0);

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    req_ready = 4'd0;
    if (state == XFER) begin
      out_valid      = req_valid[idx];
      out_data       = req_data[int'(idx)*DATA_W +: DATA_W];
      req_ready[idx] = out_ready;
    end
  end

  assign beat = out_valid & out_ready;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    done_nxt  = 4'd0;
    abort_nxt = 4'd0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (one_hot) begin
          idx_nxt   = enc;
          cnt_nxt   = '0;
          state_nxt = XFER;
        end else if (grnt != 4'd0) begin
          err_nxt = 1'b1;
        end
      end
      XFER: begin
        // a final beat wins over a grant drop in the same cycle
        if (beat && cnt == LAST) begin
          state_nxt     = REL;
          done_nxt[idx] = 1'b1;
        end else if (!grnt[idx]) begin
          state_nxt      = REL;
          abort_nxt[idx] = 1'b1;
        end else if (beat) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REL: begin
        if (grnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      done      <= 4'd0;
      abort     <= 4'd0;
      err_grant <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      done      <= done_nxt;
      abort     <= abort_nxt;
      err_grant <= err_nxt;
    end
  end

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// Directed vector bench for grant_burst_ctrl: table of per-cycle
// inputs/outputs plus hand sequences for async reset mid-burst.
module tb_grant_burst_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  grnt;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  done;
  logic [3:0]  abort;
  logic        busy;
  logic        err_grant;

  int checks;
  int failures;

  grant_burst_ctrl #(
    .DATA_W(8),
    .BURST_LEN(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .grnt(grnt),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done(done),
    .abort(abort),
    .busy(busy),
    .err_grant(err_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  g;
    logic [3:0]  rv;
    logic        ordy;
    logic [31:0] d;
    logic        ov;
    logic [7:0]  od;
    logic [3:0]  rr;
    logic [3:0]  dn;
    logic [3:0]  ab;
    logic        bz;
    logic        er;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic [3:0] g, logic [3:0] rv, logic ordy, logic [31:0] d,
    logic ov, logic [7:0] od, logic [3:0] rr,
    logic [3:0] dn, logic [3:0] ab, logic bz, logic er);
    vec_t v;
    v.g = g; v.rv = rv; v.ordy = ordy; v.d = d;
    v.ov = ov; v.od = od; v.rr = rr;
    v.dn = dn; v.ab = ab; v.bz = bz; v.er = er;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic run_vec(int n, vec_t v);
    string t;
    @(negedge clk);
    grnt      = v.g;
    req_valid = v.rv;
    out_ready = v.ordy;
    req_data  = v.d;
    #1;
    t = $sformatf("v%0d", n);
    check({t, ".out_valid"}, 32'(out_valid), 32'(v.ov));
    check({t, ".out_data"},  32'(out_data),  32'(v.od));
    check({t, ".req_ready"}, 32'(req_ready), 32'(v.rr));
    check({t, ".done"},      32'(done),      32'(v.dn));
    check({t, ".abort"},     32'(abort),     32'(v.ab));
    check({t, ".busy"},      32'(busy),      32'(v.bz));
    check({t, ".err_grant"}, 32'(err_grant), 32'(v.er));
  endtask

  int beats;
  bit dseen;
  bit aseen;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    grnt      = 4'd0;
    req_valid = 4'd0;
    out_ready = 1'b0;
    req_data  = 32'd0;

    // basic burst on requester 0, grant held after done, then illegal grant
    vq.push_back(mk(4'b0000,4'b0000,0,32'h0,        0,8'h00,4'b0000,4'b0000,4'b0000,0,0));
    vq.push_back(mk(4'b0001,4'b0001,1,32'h332211A0, 0,8'h00,4'b0000,4'b0000,4'b0000,0,0));
    vq.push_back(mk(4'b0001,4'b0001,1,32'h332211A0, 1,8'hA0,4'b0001,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0001,4'b0001,1,32'h332211A1, 1,8'hA1,4'b0001,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0001,4'b0001,1,32'h332211A2, 1,8'hA2,4'b0001,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0001,4'b0001,1,32'h332211A3, 1,8'hA3,4'b0001,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0001,4'b0001,1,32'h332211A4, 0,8'h00,4'b0000,4'b0001,4'b0000,1,0));
    vq.push_back(mk(4'b0001,4'b0001,1,32'h332211A4, 0,8'h00,4'b0000,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0000,4'b0001,1,32'h332211A4, 0,8'h00,4'b0000,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0000,4'b0001,1,32'h332211A4, 0,8'h00,4'b0000,4'b0000,4'b0000,0,0));
    vq.push_back(mk(4'b0011,4'b0011,1,32'h332211A4, 0,8'h00,4'b0000,4'b0000,4'b0000,0,0));
    vq.push_back(mk(4'b0000,4'b0000,1,32'h332211A4, 0,8'h00,4'b0000,4'b0000,4'b0000,0,1));
    vq.push_back(mk(4'b0000,4'b0000,1,32'h332211A4, 0,8'h00,4'b0000,4'b0000,4'b0000,0,0));
    // backpressure on requester 2
    vq.push_back(mk(4'b0100,4'b0100,1,32'h55C04433, 0,8'h00,4'b0000,4'b0000,4'b0000,0,0));
    vq.push_back(mk(4'b0100,4'b0100,1,32'h55C04433, 1,8'hC0,4'b0100,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0100,4'b0100,0,32'h55C14433, 1,8'hC1,4'b0000,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0100,4'b0000,1,32'h55C14433, 0,8'hC1,4'b0100,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0100,4'b0100,1,32'h55C14433, 1,8'hC1,4'b0100,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0100,4'b0100,0,32'h55C24433, 1,8'hC2,4'b0000,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0100,4'b0100,1,32'h55C24433, 1,8'hC2,4'b0100,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0100,4'b0000,0,32'h55C34433, 0,8'hC3,4'b0000,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0100,4'b0100,1,32'h55C34433, 1,8'hC3,4'b0100,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0000,4'b0000,1,32'h55C34433, 0,8'h00,4'b0000,4'b0100,4'b0000,1,0));
    vq.push_back(mk(4'b0000,4'b0000,1,32'h55C34433, 0,8'h00,4'b0000,4'b0000,4'b0000,0,0));
    // abort on requester 3 after two beats
    vq.push_back(mk(4'b1000,4'b1000,1,32'hD0665544, 0,8'h00,4'b0000,4'b0000,4'b0000,0,0));
    vq.push_back(mk(4'b1000,4'b1000,1,32'hD0665544, 1,8'hD0,4'b1000,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b1000,4'b1000,1,32'hD1665544, 1,8'hD1,4'b1000,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0000,4'b0000,1,32'hD2665544, 0,8'hD2,4'b1000,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0000,4'b0000,1,32'hD2665544, 0,8'h00,4'b0000,4'b0000,4'b1000,1,0));
    vq.push_back(mk(4'b0000,4'b0000,1,32'hD2665544, 0,8'h00,4'b0000,4'b0000,4'b0000,0,0));
    // final beat coincides with grant drop on requester 1
    vq.push_back(mk(4'b0010,4'b0010,1,32'h7766B088, 0,8'h00,4'b0000,4'b0000,4'b0000,0,0));
    vq.push_back(mk(4'b0010,4'b0010,1,32'h7766B088, 1,8'hB0,4'b0010,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0010,4'b0010,1,32'h7766B188, 1,8'hB1,4'b0010,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0010,4'b0010,1,32'h7766B288, 1,8'hB2,4'b0010,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0000,4'b0010,1,32'h7766B388, 1,8'hB3,4'b0010,4'b0000,4'b0000,1,0));
    vq.push_back(mk(4'b0000,4'b0000,1,32'h7766B388, 0,8'h00,4'b0000,4'b0010,4'b0000,1,0));
    vq.push_back(mk(4'b0000,4'b0000,1,32'h7766B388, 0,8'h00,4'b0000,4'b0000,4'b0000,0,0));

    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) run_vec(i, vq[i]);

    // async reset after the first beat of a burst
    @(negedge clk);
    grnt = 4'b0001; req_valid = 4'b0001; out_ready = 1'b1;
    req_data = 32'h000000E0;
    @(negedge clk);
    #1;
    check("rst.pre_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.busy",      32'(busy),      32'd0);
    check("rst.done",      32'(done),      32'd0);
    check("rst.abort",     32'(abort),     32'd0);
    grnt = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("post_rst.busy", 32'(busy), 32'd0);
    end

    // fresh burst after reset must run all four beats
    @(negedge clk);
    grnt = 4'b0001; req_valid = 4'b0001; out_ready = 1'b1;
    beats = 0; dseen = 0; aseen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (abort != 4'd0) aseen = 1;
      if (done == 4'b0001) begin
        dseen = 1;
        break;
      end
      if (out_valid && out_ready) beats++;
    end
    check("rst_burst.done_seen", 32'(dseen), 32'd1);
    check("rst_burst.beats",     32'(beats), 32'd4);
    check("rst_burst.no_abort",  32'(aseen), 32'd0);
    grnt = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    check("rst_burst.idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
